// File: rtl/flux_tag_merge.sv
// Multi-flux tagging merger: per-flux FIFOs feed a round-robin arbiter that
// emits {flux_index, payload} words, skipping fluxes the downstream reports full.
module flux_tag_merge #(
    parameter int FLUX       = 2,
    parameter int DATA_WIDTH = 8,
    parameter int TAG_WIDTH  = $clog2(FLUX),
    parameter int WIDTH      = DATA_WIDTH + TAG_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [FLUX-1:0]            in_port_write,
    input  logic [FLUX*DATA_WIDTH-1:0] in_port_datain,
    output logic [FLUX-1:0]            in_port_full,
    output logic                       out_port_write,
    output logic [WIDTH-1:0]           out_port_dataout,
    input  logic [FLUX-1:0]            out_port_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [FLUX][DEPTH];
    logic [PTR_W-1:0]      rd_ptr [FLUX];
    logic [PTR_W-1:0]      wr_ptr [FLUX];
    logic [CNT_W-1:0]      count  [FLUX];
    logic [TAG_WIDTH-1:0]  rr;

    logic [FLUX-1:0]       push;
    logic [FLUX-1:0]       pop;
    logic [FLUX-1:0]       eligible;
    logic                  grant_valid;
    logic [TAG_WIDTH-1:0]  grant_idx;
    logic [DATA_WIDTH-1:0] head;

    always_comb begin
        for (int f = 0; f < FLUX; f++) begin
            in_port_full[f] = (count[f] == CNT_W'(DEPTH));
            push[f]         = in_port_write[f] && (count[f] != CNT_W'(DEPTH));
            eligible[f]     = (count[f] != '0) && !out_port_full[f];
        end
    end

    // Search starts at rr and wraps; the first eligible flux wins.
    always_comb begin
        int cand;
        cand        = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < FLUX; k++) begin
            cand = (int'(rr) + k) % FLUX;
            if (!grant_valid && eligible[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = TAG_WIDTH'(cand);
            end
        end
    end

    always_comb begin
        for (int f = 0; f < FLUX; f++) begin
            pop[f] = grant_valid && (grant_idx == TAG_WIDTH'(f));
        end
        head = mem[grant_idx][rd_ptr[grant_idx]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < FLUX; f++) begin
                rd_ptr[f] <= '0;
                wr_ptr[f] <= '0;
                count[f]  <= '0;
            end
        end else begin
            for (int f = 0; f < FLUX; f++) begin
                if (push[f]) wr_ptr[f] <= wr_ptr[f] + PTR_W'(1);
                if (pop[f])  rd_ptr[f] <= rd_ptr[f] + PTR_W'(1);
                case ({push[f], pop[f]})
                    2'b10:   count[f] <= count[f] + CNT_W'(1);
                    2'b01:   count[f] <= count[f] - CNT_W'(1);
                    default: count[f] <= count[f];
                endcase
            end
        end
    end

    // Storage is left unreset; counts alone define which entries are live.
    always_ff @(posedge clk) begin
        for (int f = 0; f < FLUX; f++) begin
            if (!rst && push[f]) begin
                mem[f][wr_ptr[f]] <= in_port_datain[f*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr               <= '0;
            out_port_write   <= 1'b0;
            out_port_dataout <= '0;
        end else begin
            out_port_write <= grant_valid;
            if (grant_valid) begin
                out_port_dataout <= {grant_idx, head};
                if (int'(grant_idx) == FLUX - 1) rr <= '0;
                else                             rr <= grant_idx + TAG_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_flux_tag_merge.sv
// Scoreboard bench for flux_tag_merge: stimulus queues the expected tagged words,
// a negedge monitor pops and compares every word the DUT emits.
module tb_flux_tag_merge;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  in_port_write;
    logic [15:0] in_port_datain;
    logic [1:0]  in_port_full;
    logic        out_port_write;
    logic [8:0]  out_port_dataout;
    logic [1:0]  out_port_full;

    int vectors = 0;
    int miscompares = 0;
    bit mon_en = 1'b0;
    logic [8:0] exp_q[$];

    flux_tag_merge #(.FLUX(2), .DATA_WIDTH(8), .DEPTH(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_port_write    (in_port_write),
        .in_port_datain   (in_port_datain),
        .in_port_full     (in_port_full),
        .out_port_write   (out_port_write),
        .out_port_dataout (out_port_dataout),
        .out_port_full    (out_port_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && out_port_write !== 1'b0) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_word: got %0h (write=%b), expected none at %0t",
                         out_port_dataout, out_port_write, $time);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("out_word", {23'd0, out_port_dataout}, {23'd0, e});
            end
        end
    end

    // Presents one write on flux f for one edge; returns at the next negedge.
    task automatic write_one(input int f, input logic [7:0] d);
        in_port_write = 2'b00;
        in_port_write[f] = 1'b1;
        in_port_datain[f*8 +: 8] = d;
        @(negedge clk);
        in_port_write = 2'b00;
    endtask

    initial begin
        logic [1:0] bp_pat;
        rst = 1'b1;
        in_port_write = 2'b00;
        in_port_datain = 16'h0000;
        out_port_full = 2'b00;

        // Reset / idle
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_write", {31'd0, out_port_write}, 32'd0);
            check("rst_data", {23'd0, out_port_dataout}, 32'd0);
            check("rst_full", {30'd0, in_port_full}, 32'd0);
        end
        rst = 1'b0;
        mon_en = 1'b1;

        // Single word latency on each flux
        exp_q.push_back(9'h001);
        write_one(0, 8'h01);
        check("lat0_early", {31'd0, out_port_write}, 32'd0);
        @(negedge clk);
        check("lat0_write", {31'd0, out_port_write}, 32'd1);
        check("lat0_data", {23'd0, out_port_dataout}, 32'h001);
        @(negedge clk);
        exp_q.push_back(9'h101);
        write_one(1, 8'h01);
        check("lat1_early", {31'd0, out_port_write}, 32'd0);
        @(negedge clk);
        check("lat1_write", {31'd0, out_port_write}, 32'd1);
        check("lat1_data", {23'd0, out_port_dataout}, 32'h101);
        @(negedge clk);

        // Round-robin, both fluxes preloaded with 3 words
        out_port_full = 2'b11;
        for (int i = 0; i < 3; i++) begin
            in_port_write = 2'b11;
            in_port_datain = {8'h20 + 8'(i), 8'h10 + 8'(i)};
            @(negedge clk);
        end
        in_port_write = 2'b00;
        exp_q.push_back(9'h010); exp_q.push_back(9'h120);
        exp_q.push_back(9'h011); exp_q.push_back(9'h121);
        exp_q.push_back(9'h012); exp_q.push_back(9'h122);
        out_port_full = 2'b00;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rr_back2back", {31'd0, out_port_write}, 32'd1);
        end
        @(negedge clk);

        // Per-flux backpressure: flux 0 blocked for 4 cycles
        out_port_full = 2'b11;
        for (int i = 0; i < 3; i++) begin
            in_port_write = 2'b11;
            in_port_datain = {8'h40 + 8'(i), 8'h30 + 8'(i)};
            @(negedge clk);
        end
        in_port_write = 2'b00;
        exp_q.push_back(9'h140); exp_q.push_back(9'h141); exp_q.push_back(9'h142);
        exp_q.push_back(9'h030); exp_q.push_back(9'h031); exp_q.push_back(9'h032);
        out_port_full = 2'b01;
        bp_pat = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_write", {31'd0, out_port_write}, (i < 3) ? 32'd1 : 32'd0);
        end
        out_port_full = 2'b00;
        repeat (4) @(negedge clk);

        // FIFO full / drop on flux 0
        out_port_full = 2'b11;
        for (int i = 0; i < 5; i++) begin
            in_port_write = 2'b01;
            in_port_datain[7:0] = 8'h50 + 8'(i);
            @(negedge clk);
            check("fill_full0", {31'd0, in_port_full[0]}, (i >= 3) ? 32'd1 : 32'd0);
        end
        in_port_write = 2'b00;
        exp_q.push_back(9'h050); exp_q.push_back(9'h051);
        exp_q.push_back(9'h052); exp_q.push_back(9'h053);
        out_port_full = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("drain_write", {31'd0, out_port_write}, 32'd1);
        end
        @(negedge clk);
        check("drain_stop", {31'd0, out_port_write}, 32'd0);
        check("drain_full", {30'd0, in_port_full}, 32'd0);

        // Reset mid-stream with data held in both FIFOs
        out_port_full = 2'b11;
        for (int i = 0; i < 2; i++) begin
            in_port_write = 2'b11;
            in_port_datain = {8'h70 + 8'(i), 8'h60 + 8'(i)};
            @(negedge clk);
        end
        rst = 1'b1;
        in_port_write = 2'b01;
        in_port_datain = 16'h0066;
        @(negedge clk);
        check("midrst_write", {31'd0, out_port_write}, 32'd0);
        check("midrst_data", {23'd0, out_port_dataout}, 32'd0);
        check("midrst_full", {30'd0, in_port_full}, 32'd0);
        rst = 1'b0;
        in_port_write = 2'b00;
        out_port_full = 2'b00;
        @(negedge clk);
        check("postrst_idle", {31'd0, out_port_write}, 32'd0);
        exp_q.push_back(9'h081);
        exp_q.push_back(9'h180);
        in_port_write = 2'b11;
        in_port_datain = 16'h8081;
        @(negedge clk);
        in_port_write = 2'b00;

        // Drain with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
